// File: rtl/star_arb_n_pkg.sv
// Shared types and helpers for the star_arb_n chained packet arbiter.
package star_arb_n_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOCK_SRC,
        LOCK_PRV
    } state_t;

    typedef logic [1:0] pick_t;
    localparam pick_t PICK_NONE = 2'd0;
    localparam pick_t PICK_SRC  = 2'd1;
    localparam pick_t PICK_PRV  = 2'd2;

    // Index width for NUM_SRC sources; a single source still needs one bit.
    function automatic int sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/star_arb_n_if.sv
// Stream bundle of star_arb_n: local sources, chained upstream and merged output.
interface star_arb_n_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_SRC    = 4
);
    logic [NUM_SRC*DATA_WIDTH-1:0] src_TDATA;
    logic [NUM_SRC-1:0]            src_TVALID;
    logic [NUM_SRC-1:0]            src_TREADY;
    logic [NUM_SRC-1:0]            src_TLAST;
    logic [DATA_WIDTH-1:0]         prv_TDATA;
    logic                          prv_TVALID;
    logic                          prv_TREADY;
    logic                          prv_TLAST;
    logic                          prv_TUSER;
    logic [DATA_WIDTH-1:0]         res_TDATA;
    logic                          res_TVALID;
    logic                          res_TREADY;
    logic                          res_TLAST;
    logic                          res_TUSER;

    modport master (
        output src_TDATA, src_TVALID, src_TLAST,
        output prv_TDATA, prv_TVALID, prv_TLAST, prv_TUSER,
        output res_TREADY,
        input  src_TREADY, prv_TREADY,
        input  res_TDATA, res_TVALID, res_TLAST, res_TUSER
    );

    modport slave (
        input  src_TDATA, src_TVALID, src_TLAST,
        input  prv_TDATA, prv_TVALID, prv_TLAST, prv_TUSER,
        input  res_TREADY,
        output src_TREADY, prv_TREADY,
        output res_TDATA, res_TVALID, res_TLAST, res_TUSER
    );
endinterface

// File: rtl/star_arb_n_rr_pick.sv
// Round-robin first-one finder: lowest requester at or after ptr, else lowest overall.
module rr_pick
    import star_arb_n_pkg::*;
#(
    parameter int N = 4,
    localparam int SW = sel_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] idx,
    output logic          any
);

    always_comb begin
        idx = '0;
        any = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = SW'(i);
        end
        // Second pass overrides with the wrap-free candidate when one exists.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) idx = SW'(i);
        end
    end

endmodule

// File: rtl/star_arb_n.sv
// N-source packet-atomic star-token arbiter for a daisy chain of nodes.
// Define STAR_ARB_N_OUT_REG_EN to register res_* through a 2-entry skid buffer.
module star_arb_n
    import star_arb_n_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int NUM_SRC         = 4,
    parameter int START_WITH_STAR = 0
) (
    input  logic         clk,
    input  logic         rstn,
    star_arb_n_if.slave  bus,
    output logic         star_held,
    output logic         star_err
);

    localparam int SW = sel_w(NUM_SRC);

    state_t             state_reg, state_next;
    logic [SW-1:0]      sel_idx_reg, sel_idx_next;
    logic [SW-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [NUM_SRC-1:0] served_reg, served_next;
    logic               star_reg, star_next;
    logic               star_err_reg, star_err_next;

    logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
    logic [SW-1:0]         idx_u, idx_a, pick_idx;
    logic                  any_u, any_a;
    pick_t                 pick;
    logic                  sel_valid, sel_last, sel_user, accept, out_ready;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_SRC-1:0]    src_ready, others;
    logic                  prv_ready, handoff_flit, star_in_flit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign src_data[gi] = bus.src_TDATA[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_pick #(.N(NUM_SRC)) u_pick_unserved (
        .req (bus.src_TVALID & ~served_reg),
        .ptr (rr_ptr_reg),
        .idx (idx_u),
        .any (any_u)
    );

    rr_pick #(.N(NUM_SRC)) u_pick_all (
        .req (bus.src_TVALID),
        .ptr (rr_ptr_reg),
        .idx (idx_a),
        .any (any_a)
    );

    always_comb begin
        pick     = PICK_NONE;
        pick_idx = sel_idx_reg;
        unique case (state_reg)
            IDLE: begin
                if (star_reg && any_u) begin
                    pick     = PICK_SRC;
                    pick_idx = idx_u;
                end else if (bus.prv_TVALID) begin
                    pick = PICK_PRV;
                end else if (any_a) begin
                    pick     = PICK_SRC;
                    pick_idx = idx_a;
                end
            end
            LOCK_SRC: pick = PICK_SRC;
            LOCK_PRV: pick = PICK_PRV;
            default:  pick = PICK_NONE;
        endcase
    end

    always_comb begin
        sel_valid    = 1'b0;
        sel_data     = '0;
        sel_last     = 1'b0;
        sel_user     = 1'b0;
        src_ready    = '0;
        prv_ready    = 1'b0;
        handoff_flit = 1'b0;
        star_in_flit = 1'b0;
        others       = bus.src_TVALID & ~served_reg & ~(NUM_SRC'(1) << pick_idx);
        if (pick == PICK_SRC) begin
            sel_valid           = bus.src_TVALID[pick_idx];
            sel_data            = src_data[pick_idx];
            sel_last            = bus.src_TLAST[pick_idx];
            // The star leaves only once no other unserved local source is waiting.
            handoff_flit        = sel_last && star_reg && (others == '0);
            sel_user            = handoff_flit;
            src_ready[pick_idx] = out_ready && rstn;
        end else if (pick == PICK_PRV) begin
            sel_valid    = bus.prv_TVALID;
            sel_data     = bus.prv_TDATA;
            sel_last     = bus.prv_TLAST;
            star_in_flit = bus.prv_TLAST && bus.prv_TUSER;
            sel_user     = star_in_flit && !star_reg;
            prv_ready    = out_ready && rstn;
        end
        accept = sel_valid && out_ready;
    end

    always_comb begin
        state_next    = state_reg;
        sel_idx_next  = sel_idx_reg;
        rr_ptr_next   = rr_ptr_reg;
        served_next   = served_reg;
        star_next     = star_reg;
        star_err_next = star_err_reg;
        if (accept) begin
            state_next   = sel_last ? IDLE : ((pick == PICK_SRC) ? LOCK_SRC : LOCK_PRV);
            sel_idx_next = pick_idx;
            if ((pick == PICK_SRC) && (state_reg == IDLE))
                rr_ptr_next = (int'(pick_idx) == NUM_SRC - 1) ? '0 : pick_idx + 1'b1;
            if ((pick == PICK_SRC) && sel_last && star_reg)
                served_next[pick_idx] = 1'b1;
            if (handoff_flit) begin
                star_next   = 1'b0;
                served_next = '0;
            end
            // Arrival after a same-cycle handoff is legal; only a true duplicate is an error.
            if (star_in_flit) begin
                if (star_reg && !handoff_flit) star_err_next = 1'b1;
                star_next   = 1'b1;
                served_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            sel_idx_reg  <= '0;
            rr_ptr_reg   <= '0;
            served_reg   <= '0;
            star_reg     <= (START_WITH_STAR != 0);
            star_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sel_idx_reg  <= sel_idx_next;
            rr_ptr_reg   <= rr_ptr_next;
            served_reg   <= served_next;
            star_reg     <= star_next;
            star_err_reg <= star_err_next;
        end
    end

`ifdef STAR_ARB_N_OUT_REG_EN
    logic [DATA_WIDTH-1:0] skid_data [2];
    logic [1:0]            skid_last, skid_user;
    logic [1:0]            cnt_reg;
    logic                  rd_reg, wr_ptr, pop;

    assign out_ready = (cnt_reg != 2'd2);
    assign pop       = (cnt_reg != 2'd0) && bus.res_TREADY;
    assign wr_ptr    = rd_reg ^ cnt_reg[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg <= '0;
            rd_reg  <= 1'b0;
        end else begin
            cnt_reg <= cnt_reg + {1'b0, accept} - {1'b0, pop};
            rd_reg  <= rd_reg ^ pop;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            skid_data[wr_ptr] <= sel_data;
            skid_last[wr_ptr] <= sel_last;
            skid_user[wr_ptr] <= sel_user;
        end
    end

    assign bus.res_TVALID = (cnt_reg != 2'd0);
    assign bus.res_TDATA  = skid_data[rd_reg];
    assign bus.res_TLAST  = skid_last[rd_reg];
    assign bus.res_TUSER  = skid_user[rd_reg];
`else
    assign out_ready      = bus.res_TREADY;
    assign bus.res_TVALID = sel_valid && rstn;
    assign bus.res_TDATA  = sel_data;
    assign bus.res_TLAST  = sel_last;
    assign bus.res_TUSER  = sel_user && sel_last;
`endif

    assign bus.src_TREADY = src_ready;
    assign bus.prv_TREADY = prv_ready;
    assign star_held      = star_reg;
    assign star_err       = star_err_reg;

endmodule

// File: tb/tb_star_arb_n.sv
// Scoreboard bench for star_arb_n: three local sources, one chained stream, star start.
module tb_star_arb_n;

    localparam int DW = 32;
    localparam int NS = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } flit_t;

    logic clk = 1'b0;
    logic rstn;
    logic star_held, star_err;

    always #5 clk = ~clk;

    star_arb_n_if #(.DATA_WIDTH(DW), .NUM_SRC(NS)) bus ();

    star_arb_n #(.DATA_WIDTH(DW), .NUM_SRC(NS), .START_WITH_STAR(1)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus.slave),
        .star_held (star_held),
        .star_err  (star_err)
    );

    flit_t in_q [4][$];
    flit_t exp_q[$];
    logic  en [4];
    logic  [3:0] fire;
    logic  tog_mode = 1'b0;
    logic  probe_en = 1'b0;
    int    n_checks = 0;
    int    n_pass = 0;
    int    out_count = 0;
    int    spurious = 0;
    int    cyc = 0;
    int    t0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    // Stream 3 is the chained upstream; expected user is what res_TUSER must carry.
    task automatic push_pkt(input int s, input int n, input logic [DW-1:0] base,
                            input logic user_mid, input logic user_last, input logic exp_last_user);
        flit_t f;
        flit_t e;
        for (int k = 0; k < n; k++) begin
            f.data = base + DW'(k);
            f.last = (k == n - 1);
            f.user = f.last ? user_last : user_mid;
            in_q[s].push_back(f);
            e      = f;
            e.user = f.last ? exp_last_user : 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_drain"}, 64'(exp_q.size()), 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic wait_out(input int target, input string tag);
        int n = 0;
        while (out_count < target && n < 500) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_wait"}, 64'(out_count >= target), 1);
    endtask

    initial begin : drive
        flit_t e;
        bus.src_TDATA  = '0;
        bus.src_TVALID = '0;
        bus.src_TLAST  = '0;
        bus.prv_TDATA  = '0;
        bus.prv_TVALID = 1'b0;
        bus.prv_TLAST  = 1'b0;
        bus.prv_TUSER  = 1'b0;
        bus.res_TREADY = 1'b1;
        forever begin
            @(negedge clk);
            for (int s = 0; s < NS; s++) fire[s] = bus.src_TVALID[s] && bus.src_TREADY[s];
            fire[3] = bus.prv_TVALID && bus.prv_TREADY;
            if (bus.res_TVALID && bus.res_TREADY) begin
                if (exp_q.size() == 0) begin
                    spurious++;
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("data#%0d", out_count), 64'(bus.res_TDATA), 64'(e.data));
                    check($sformatf("last#%0d", out_count), 64'(bus.res_TLAST), 64'(e.last));
                    check($sformatf("user#%0d", out_count), 64'(bus.res_TUSER), 64'(e.user));
                    $display("out #%0d data=%0h last=%0b user=%0b star_held=%0b",
                             out_count, bus.res_TDATA, bus.res_TLAST, bus.res_TUSER, star_held);
                    out_count++;
                end
            end
            if (probe_en && fire[0]) check("star_held_src0", 64'(star_held), 1);
            @(posedge clk);
            #1;
            for (int s = 0; s < 4; s++) begin
                if (fire[s] && in_q[s].size() > 0) void'(in_q[s].pop_front());
            end
            cyc++;
            bus.res_TREADY = tog_mode ? cyc[0] : 1'b1;
            for (int s = 0; s < NS; s++) begin
                if (en[s] && in_q[s].size() > 0) begin
                    bus.src_TVALID[s]          = 1'b1;
                    bus.src_TDATA[s*DW +: DW]  = in_q[s][0].data;
                    bus.src_TLAST[s]           = in_q[s][0].last;
                end else begin
                    bus.src_TVALID[s]          = 1'b0;
                    bus.src_TDATA[s*DW +: DW]  = '0;
                    bus.src_TLAST[s]           = 1'b0;
                end
            end
            if (en[3] && in_q[3].size() > 0) begin
                bus.prv_TVALID = 1'b1;
                bus.prv_TDATA  = in_q[3][0].data;
                bus.prv_TLAST  = in_q[3][0].last;
                bus.prv_TUSER  = in_q[3][0].user;
            end else begin
                bus.prv_TVALID = 1'b0;
                bus.prv_TDATA  = '0;
                bus.prv_TLAST  = 1'b0;
                bus.prv_TUSER  = 1'b0;
            end
        end
    end

    initial begin : main
        for (int s = 0; s < 4; s++) en[s] = 1'b1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_res_valid", 64'(bus.res_TVALID), 0);
        check("rst_src_ready", 64'(bus.src_TREADY), 0);
        check("rst_prv_ready", 64'(bus.prv_TREADY), 0);
        check("rst_star_held", 64'(star_held), 1);
        check("rst_star_err", 64'(star_err), 0);
        rstn = 1'b1;
        @(posedge clk);
        #2;

        // Star held from reset: each source served once, last one hands the star on.
        push_pkt(0, 2, 32'h1000, 0, 0, 0);
        push_pkt(1, 2, 32'h1100, 0, 0, 0);
        push_pkt(2, 2, 32'h1200, 0, 0, 1);
        wait_drain("t1");
        check("t1_star_gone", 64'(star_held), 0);

        // No star: chained stream wins over a local source, TUSER forwarded.
        push_pkt(3, 2, 32'h2000, 0, 0, 0);
        push_pkt(1, 2, 32'h2100, 0, 0, 0);
        wait_drain("t2");
        check("t2_star", 64'(star_held), 0);

        // Star arrives on prv; mid-packet TUSER forced low; src0 then takes and passes it.
        probe_en = 1'b1;
        push_pkt(3, 3, 32'h3000, 1, 1, 1);
        push_pkt(0, 2, 32'h3100, 0, 0, 1);
        wait_drain("t3");
        probe_en = 1'b0;
        check("t3_star_gone", 64'(star_held), 0);

        // Regain star, then src1 mid-packet while src0 and prv request.
        push_pkt(3, 1, 32'h4000, 0, 1, 1);
        wait_drain("t4a");
        check("t4_star_in", 64'(star_held), 1);
        en[0] = 1'b0;
        en[3] = 1'b0;
        t0 = out_count;
        push_pkt(1, 4, 32'h4100, 0, 0, 0);
        push_pkt(0, 2, 32'h4200, 0, 0, 1);
        push_pkt(3, 1, 32'h4300, 0, 0, 0);
        wait_out(t0 + 1, "t4");
        #2;
        en[0] = 1'b1;
        en[3] = 1'b1;
        wait_drain("t4b");
        check("t4_star_gone", 64'(star_held), 0);

        // Duplicate star: second star flit forwarded with TUSER=0 and flags star_err.
        push_pkt(3, 1, 32'h5000, 0, 1, 1);
        push_pkt(3, 1, 32'h5100, 0, 1, 0);
        wait_drain("t5a");
        check("t5_star_err", 64'(star_err), 1);
        check("t5_star_held", 64'(star_held), 1);
        push_pkt(2, 1, 32'h5200, 0, 0, 1);
        wait_drain("t5b");
        check("t5_err_sticky", 64'(star_err), 1);
        check("t5_star_gone", 64'(star_held), 0);

        // Throttled output, then reset in the middle of a packet.
        tog_mode = 1'b1;
        t0 = out_count;
        push_pkt(0, 6, 32'h6000, 0, 0, 0);
        wait_out(t0 + 3, "t6");
        #2;
        rstn = 1'b0;
        #3;
        check("t6_out_count", 64'(out_count - t0), 3);
        check("t6_res_valid", 64'(bus.res_TVALID), 0);
        check("t6_src_ready", 64'(bus.src_TREADY), 0);
        check("t6_star_held", 64'(star_held), 1);
        check("t6_star_err", 64'(star_err), 0);
        exp_q.delete();
        in_q[0].delete();
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        tog_mode = 1'b0;
        push_pkt(1, 1, 32'h6100, 0, 0, 1);
        wait_drain("t6b");
        check("t6_star_gone", 64'(star_held), 0);

        check("spurious_out", 64'(spurious), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
